// File: rtl/mc14500_pkg.sv
// ============================================================================
// Module  : mc14500_pkg
// Purpose : Shared constants and enums for the MC14500B system.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc14500_pkg;

  localparam int ADDR_W = 8;

  typedef enum logic [3:0] {
    NOP0 = 4'h0,
    LD   = 4'h1,
    LDC  = 4'h2,
    AND  = 4'h3,
    ANDC = 4'h4,
    OR   = 4'h5,
    ORC  = 4'h6,
    XNOR = 4'h7,
    STO  = 4'h8,
    STOC = 4'h9,
    IEN  = 4'hA,
    OEN  = 4'hB,
    JMP  = 4'hC,
    RTN  = 4'hD,
    SKZ  = 4'hE,
    NOPF = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_JMP  = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4
  } pc_action_t;

endpackage

`default_nettype wire

// File: rtl/return_stack.sv
// ============================================================================
// Module  : return_stack
// Purpose : Bounded LIFO of return addresses, indexed by its own depth count.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   depth
);
  import mc14500_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   c_full    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   c_one     = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_depth;
  logic [PTR_W-1:0] w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_depth == c_full);
  assign empty     = (r_depth == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  // When full the low pointer bits wrap to 0, so depth-1 still lands on the last slot.
  assign w_top_idx = r_depth[PTR_W-1:0] - c_ptr_one;
  assign top       = r_mem[w_top_idx];
  assign depth     = r_depth;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_depth <= '0;
    end else if (w_do_pop) begin
      r_depth <= r_depth - c_one;
    end else if (w_do_push) begin
      r_depth <= r_depth + c_one;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_do_push && !w_do_pop) begin
      r_mem[r_depth[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/program_counter.sv
// ============================================================================
// Module  : program_counter
// Purpose : MC14500B program counter with call/return stack and sticky errors.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_counter #(
  parameter int ADDR_W      = mc14500_pkg::ADDR_W,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           jmp,
  input  logic                           call,
  input  logic                           rtn,
  input  logic [ADDR_W-1:0]              jmp_target,
  output logic [ADDR_W-1:0]              pc,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           overflow,
  output logic                           underflow
);
  import mc14500_pkg::*;

  localparam logic [ADDR_W-1:0] c_pc_one = ADDR_W'(1);

  logic [ADDR_W-1:0] r_pc;
  logic              r_overflow;
  logic              r_underflow;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_stk_top;
  logic              w_stk_full;
  logic              w_stk_empty;
  logic              w_push;
  logic              w_pop;
  pc_action_t        w_action;

  assign w_pc_inc = r_pc + c_pc_one;

  always_comb begin
    w_action = PC_HOLD;
    if (enable) begin
      if (rtn)              w_action = PC_RET;
      else if (jmp && call) w_action = PC_CALL;
      else if (jmp)         w_action = PC_JMP;
      else                  w_action = PC_INC;
    end
  end

  // Stack reset has priority inside the stack, so a reset cycle never pushes.
  assign w_push = (w_action == PC_CALL) && !w_stk_full;
  assign w_pop  = (w_action == PC_RET) && !w_stk_empty;

  return_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top       (w_stk_top),
    .full      (w_stk_full),
    .empty     (w_stk_empty),
    .depth     (depth)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (w_action)
        PC_RET: begin
          if (w_stk_empty) begin
            r_underflow <= 1'b1;
            r_pc        <= w_pc_inc;
          end else begin
            r_pc        <= w_stk_top;
          end
        end
        PC_CALL: begin
          if (w_stk_full) begin
            r_overflow <= 1'b1;
            r_pc       <= w_pc_inc;
          end else begin
            r_pc       <= jmp_target;
          end
        end
        PC_JMP:  r_pc <= jmp_target;
        PC_INC:  r_pc <= w_pc_inc;
        default: r_pc <= r_pc;
      endcase
    end
  end

  assign pc        = r_pc;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_program_counter.sv
// ============================================================================
// Module  : tb_program_counter
// Purpose : Directed scoreboard bench for program_counter (ADDR_W=8, depth 4).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_counter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       jmp;
  logic       call;
  logic       rtn;
  logic [7:0] jmp_target;
  logic [7:0] pc;
  logic [2:0] depth;
  logic       overflow;
  logic       underflow;

  program_counter #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .jmp        (jmp),
    .call       (call),
    .rtn        (rtn),
    .jmp_target (jmp_target),
    .pc         (pc),
    .depth      (depth),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pc;
    logic [2:0] depth;
    logic       ov;
    logic       un;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;

  // Reference model, independent of the RTL structure.
  logic [7:0] m_pc = 8'h00;
  logic [7:0] m_stack[$];
  logic       m_ov = 1'b0;
  logic       m_un = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic en, input logic j, input logic c,
                            input logic rt, input logic [7:0] tgt);
    if (r) begin
      m_pc = 8'h00;
      m_stack.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else if (en) begin
      if (rt) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_un = 1'b1; m_pc = m_pc + 8'h01; end
      end else if (j && c) begin
        if (m_stack.size() < 4) begin m_stack.push_back(m_pc + 8'h01); m_pc = tgt; end
        else begin m_ov = 1'b1; m_pc = m_pc + 8'h01; end
      end else if (j) begin
        m_pc = tgt;
      end else begin
        m_pc = m_pc + 8'h01;
      end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic en, input logic j,
                      input logic c, input logic rt, input logic [7:0] tgt);
    exp_t e;
    reset = r; enable = en; jmp = j; call = c; rtn = rt; jmp_target = tgt;
    model_step(r, en, j, c, rt, tgt);
    e.pc = m_pc; e.depth = 3'(m_stack.size()); e.ov = m_ov; e.un = m_un;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".pc"},    32'(pc),        32'(e.pc));
      chk({tag, ".depth"}, 32'(depth),     32'(e.depth));
      chk({tag, ".ovf"},   32'(overflow),  32'(e.ov));
      chk({tag, ".unf"},   32'(underflow), 32'(e.un));
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_call(input string tag, input logic [7:0] tgt);
    step(tag, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, tgt);
  endtask

  task automatic do_ret(input string tag);
    step(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; jmp = 1'b0; call = 1'b0; rtn = 1'b0; jmp_target = 8'h00;
    #1;

    // Reset and idle counting
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("reset.pc_const", 32'(pc), 32'h0);
    for (int i = 0; i < 5; i++) idle("idle");
    chk("idle.pc5", 32'(pc), 32'h5);

    // Single call / return
    step("reset2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) idle("to3");
    do_call("call40", 8'h40);
    chk("call40.pc_const", 32'(pc), 32'h40);
    idle("sub41");
    idle("sub42");
    do_ret("ret4");
    chk("ret4.pc_const", 32'(pc), 32'h4);

    // Nested calls to overflow, then returns to underflow
    do_call("nest1", 8'h10);
    do_call("nest2", 8'h20);
    do_call("nest3", 8'h30);
    do_call("nest4", 8'h50);
    do_call("nest5_ovf", 8'h60);
    chk("nest5.pc_const", 32'(pc), 32'h51);
    chk("nest5.depth_const", 32'(depth), 32'h4);
    for (int i = 0; i < 4; i++) do_ret("unwind");
    chk("unwind.pc_const", 32'(pc), 32'h5);
    do_ret("ret_unf");
    chk("ret_unf.pc_const", 32'(pc), 32'h6);

    // Reset mid-call at depth 2 with both flags set
    do_call("pre1", 8'h70);
    do_call("pre2", 8'h80);
    reset = 1'b1; enable = 1'b1; jmp = 1'b1; call = 1'b1; rtn = 1'b0; jmp_target = 8'h90;
    #3;
    chk("rst_between_edges.pc", 32'(pc), 32'h80);
    chk("rst_between_edges.depth", 32'(depth), 32'h2);
    step("rst_call", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h90);

    // Wrap-around of increment and pushed return address
    step("jmpFE", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFE);
    idle("toFF");
    idle("wrap0");
    chk("wrap0.pc_const", 32'(pc), 32'h0);
    step("jmpFF", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    do_call("callFF", 8'h80);
    do_ret("retwrap");
    chk("retwrap.pc_const", 32'(pc), 32'h0);

    // Tight loop, return priority, enable hold, call without jmp
    step("tight", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    do_call("call20", 8'h20);
    step("rtn_wins", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h99);
    chk("rtn_wins.pc_const", 32'(pc), 32'h1);
    step("hold", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33);
    step("call_only", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/program_counter.md
Name: program_counter

Overview:
- Program counter and return-address stack for the MC14500B system. Sits directly downstream of the reset module and is cleared by its `pc_reset` output, which drives this block's `reset`.
- Supplies the instruction-ROM address each cycle.
- Consumes the ICU's `JMP` / `RTN` flag decodes plus a call qualifier.
- Supports jumps, bounded-depth subroutine calls and returns, and sticky stack-error reporting.

Parameters:
- ADDR_W, 8, width of the program address and jump target.
- STACK_DEPTH, 4, number of return-address entries (power of two, ≥2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; driven from `pc_reset`.
- enable  input  1  advance strobe; when low, all state holds.
- jmp  input  1  ICU `JMP` decode: load `jmp_target` into `pc`.
- call  input  1  qualifies `jmp` as a subroutine call (push return address).
- rtn  input  1  ICU `RTN` decode: pop the return address into `pc`.
- jmp_target  input  ADDR_W  target address from the instruction operand field.
- pc  output  ADDR_W  current instruction-ROM address.
- depth  output  $clog2(STACK_DEPTH)+1  number of valid stack entries.
- overflow  output  1  sticky: a call was attempted with the stack full.
- underflow  output  1  sticky: a return was attempted with the stack empty.

Behaviour:
- One clock (`clk`); reset is synchronous and active-high, named `reset`.
- Reset (sampled at `posedge clk`, regardless of `enable`):
  - `pc`=0, `depth`=0, `overflow`=0, `underflow`=0.
  - Stack contents are don't-care.
  - Reset asserted mid-call or mid-return discards that operation entirely.
- Latency: `pc` is registered; an action sampled at edge N is visible on `pc` after edge N.
- `enable`=0: `pc`, `depth` and the flags hold; `jmp`, `call` and `rtn` are ignored.
- `enable`=1, action priority (first match wins):
  1. `rtn`=1:
     - If `depth`>0: `pc` ← top of stack; `depth`−1.
     - If `depth`=0: `underflow` ← 1; `pc` ← `pc`+1; `depth` stays 0.
  2. `jmp`=1 and `call`=1:
     - If `depth`<STACK_DEPTH: push `pc`+1 (mod 2^ADDR_W); `pc` ← `jmp_target`; `depth`+1.
     - If full: `overflow` ← 1; no push; `pc` ← `pc`+1 (call suppressed, not converted to a jump).
  3. `jmp`=1, `call`=0: `pc` ← `jmp_target`; stack unchanged.
  4. Otherwise: `pc` ← `pc`+1.
- `call` without `jmp` has no effect beyond a normal increment.
- Increment wraps: `pc`=2^ADDR_W−1 → 0. A pushed return address wraps the same way.
- A jump to the current address is legal (tight loop).
- Sticky flags clear only on `reset`. Neither flag blocks further operation.
- `depth` never exceeds STACK_DEPTH and never goes negative.
- Stack is LIFO, implemented as a register array indexed by `depth`. Top-of-stack read is combinational from the registered `depth`.

Decomposition:
- Shared package `mc14500_pkg`:
  - ADDR_W default constant.
  - Opcode enum (NOP0=0x0 … JMP=0xC, RTN=0xD, SKZ=0xE, NOPF=0xF).
  - `pc_action_t` enum {PC_HOLD, PC_INC, PC_JMP, PC_CALL, PC_RET} used by the priority decode.
- Sub-module `return_stack`:
  - Parameterised LIFO with push, pop, full, empty, top and depth.
  - Same clock and synchronous reset.
  - Push-when-full and pop-when-empty are ignored internally.
- `program_counter` holds the decode, the `pc` register and the sticky flags.

Test Plan:
- Reset then 5 enabled idle cycles → `pc` sequence 0,1,2,3,4,5; `depth`=0; flags 0.
- At `pc`=3, `jmp`=1, `call`=1, `jmp_target`=0x40, then `rtn` at `pc`=0x42 → `pc` 0x40, 0x41, 0x42, then 4; `depth` 1 then 0.
- 5 nested calls with STACK_DEPTH=4 → 4 pushes succeed; 5th sets `overflow`, `pc` increments, `depth`=4. Then 5 returns → addresses pop in LIFO order; 5th sets `underflow`, `depth`=0.
- `pc`=0xFF with `enable` idle → `pc`=0x00. A call at 0xFF pushes 0x00; the return lands at 0x00.
- Simultaneous `rtn`, `jmp` and `call` with `depth`=1 → return wins, `pc`=stacked value, no push. `enable`=0 with `jmp`=1 → `pc` unchanged.
- `reset` asserted in the same cycle as a call with `depth`=2 → next cycle `pc`=0, `depth`=0, both flags cleared; `reset` is synchronous, so no change occurs between edges.
